// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcode encodings, branch-unit state encoding
// and the width of the taken-branch performance counter.
package cpu_pkg;

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_JMP = 2'b10;
  localparam logic [1:0] BR_RSV = 2'b11;

  localparam int unsigned TAKEN_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StResolve,
    StFlush
  } br_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Request/decision bundle between decode and the branch resolution unit.
// master = decode/pipeline side, slave = branch_ctrl.
interface branch_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic                   br_valid;
  logic                   br_ready;
  logic [1:0]             br_op;
  logic [WIDTH-1:0]       rs_a;
  logic [WIDTH-1:0]       rs_b;
  logic [WIDTH-1:0]       target;
  logic [WIDTH-1:0]       pc_plus;
  logic                   stall;
  logic                   sel;
  logic [WIDTH-1:0]       next_pc;
  logic                   resolved;
  logic                   flush;
  logic                   bad_op;
  logic [TAKEN_CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, br_op, rs_a, rs_b, target, pc_plus, stall,
    input  br_ready, sel, next_pc, resolved, flush, bad_op, taken_cnt
  );

  modport slave (
    input  br_valid, br_op, rs_a, rs_b, target, pc_plus, stall,
    output br_ready, sel, next_pc, resolved, flush, bad_op, taken_cnt
  );

endinterface

// File: rtl/br_cmp.sv
// Combinational taken/not-taken decision for a branch opcode and two operands.
// Kept standalone so an early-resolve stage can reuse it.
module br_cmp
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       br_op_i,
  input  logic [WIDTH-1:0] rs_a_i,
  input  logic [WIDTH-1:0] rs_b_i,
  output logic             taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (br_op_i)
      BR_BEQ:  taken_o = (rs_a_i == rs_b_i);
      BR_BNE:  taken_o = (rs_a_i != rs_b_i);
      BR_JMP:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution unit: registers the next-PC decision, drives the BrEq mux
// select, squashes younger stages after a taken branch and counts taken branches.
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  bus
);

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

  br_state_e              state_q, state_d;
  logic                   sel_q, sel_d;
  logic [WIDTH-1:0]       next_pc_q, next_pc_d;
  logic                   bad_op_q, bad_op_d;
  logic [3:0]             flush_cnt_q, flush_cnt_d;
  logic [TAKEN_CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic                   taken;

  br_cmp #(
    .WIDTH (WIDTH)
  ) u_br_cmp (
    .br_op_i (bus.br_op),
    .rs_a_i  (bus.rs_a),
    .rs_b_i  (bus.rs_b),
    .taken_o (taken)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    next_pc_d   = next_pc_q;
    bad_op_d    = bad_op_q;
    flush_cnt_d = flush_cnt_q;
    taken_cnt_d = taken_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.br_valid && !bus.stall) begin
          state_d   = StResolve;
          sel_d     = taken;
          next_pc_d = taken ? bus.target : bus.pc_plus;
          bad_op_d  = (bus.br_op == BR_RSV);
        end
      end
      StResolve: begin
        if (!bus.stall) begin
          if (sel_q && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + TAKEN_CNT_W'(1);
          end
          // The RESOLVE cycle already counts as the first flush cycle.
          if (!sel_q || (FLUSH_CYCLES == 1)) begin
            state_d = StIdle;
          end else begin
            state_d     = StFlush;
            flush_cnt_d = FlushInit;
          end
        end
      end
      StFlush: begin
        if (!bus.stall) begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q == 4'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      next_pc_q   <= '0;
      bad_op_q    <= 1'b0;
      flush_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      next_pc_q   <= next_pc_d;
      bad_op_q    <= bad_op_d;
      flush_cnt_q <= flush_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.br_ready  = (state_q == StIdle) && !bus.stall;
  assign bus.resolved  = (state_q == StResolve) && !bus.stall;
  assign bus.bad_op    = bus.resolved && bad_op_q;
  assign bus.flush     = sel_q && ((state_q == StResolve) || (state_q == StFlush));
  assign bus.sel       = sel_q;
  assign bus.next_pc   = next_pc_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a vector table on a FLUSH_CYCLES=2 instance plus
// hand sequences for stall, mid-flush reset, a 1-cycle flush variant and saturation.
module tb_branch_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  branch_ctrl_if #(.WIDTH(16)) bus0 ();
  branch_ctrl_if #(.WIDTH(16)) bus1 ();

  branch_ctrl #(
    .WIDTH        (16),
    .FLUSH_CYCLES (2)
  ) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  branch_ctrl #(
    .WIDTH        (16),
    .FLUSH_CYCLES (1)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] t;
    logic [15:0] p;
    logic        exp_sel;
    logic [15:0] exp_pc;
    logic        exp_bad;
  } vec_t;

  vec_t vecs [7];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus0.br_valid = 1'b0; bus0.br_op = BR_BEQ; bus0.stall = 1'b0;
    bus0.rs_a = '0; bus0.rs_b = '0; bus0.target = '0; bus0.pc_plus = '0;
    bus1.br_valid = 1'b0; bus1.br_op = BR_BEQ; bus1.stall = 1'b0;
    bus1.rs_a = '0; bus1.rs_b = '0; bus1.target = '0; bus1.pc_plus = '0;
  endtask

  // Called at negedge+1 of an idle cycle; returns at negedge+1 of the next ready cycle.
  task automatic do_branch0(input vec_t v);
    int lat, fl, res, bo;
    bus0.br_op = v.op; bus0.rs_a = v.a; bus0.rs_b = v.b;
    bus0.target = v.t; bus0.pc_plus = v.p; bus0.br_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs to prove the decision was captured at acceptance.
    bus0.br_valid = 1'b0; bus0.target = 16'hDEAD; bus0.pc_plus = 16'hBEEF;
    bus0.rs_a = ~v.a; bus0.br_op = BR_RSV;
    #1;
    chk({v.name, " resolved"}, 32'(bus0.resolved), 32'd1);
    chk({v.name, " sel"}, 32'(bus0.sel), 32'(v.exp_sel));
    chk({v.name, " next_pc"}, 32'(bus0.next_pc), 32'(v.exp_pc));
    chk({v.name, " bad_op"}, 32'(bus0.bad_op), 32'(v.exp_bad));
    chk({v.name, " br_ready busy"}, 32'(bus0.br_ready), 32'd0);
    lat = 1; fl = int'(bus0.flush); res = 0; bo = 0;
    while (!bus0.br_ready && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      fl  += int'(bus0.flush);
      res += int'(bus0.resolved);
      bo  += int'(bus0.bad_op);
    end
    chk({v.name, " ready latency"}, 32'(lat), v.exp_sel ? 32'd3 : 32'd2);
    chk({v.name, " flush cycles"}, 32'(fl), v.exp_sel ? 32'd2 : 32'd0);
    chk({v.name, " extra pulses"}, 32'(res + bo), 32'd0);
    chk({v.name, " sel held"}, 32'(bus0.sel), 32'(v.exp_sel));
    chk({v.name, " next_pc held"}, 32'(bus0.next_pc), 32'(v.exp_pc));
    if (v.exp_sel && exp_cnt0 < 65535) exp_cnt0++;
    chk({v.name, " taken_cnt"}, 32'(bus0.taken_cnt), 32'(exp_cnt0));
  endtask

  // FLUSH_CYCLES=1 instance: one JMP, checked for single-cycle flush.
  task automatic jmp1(input string name, input logic [15:0] exp_cnt);
    int lat, fl;
    bus1.br_op = BR_JMP; bus1.target = 16'h0200; bus1.pc_plus = 16'h0201;
    bus1.br_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.br_valid = 1'b0;
    #1;
    chk({name, " resolved"}, 32'(bus1.resolved), 32'd1);
    chk({name, " next_pc"}, 32'(bus1.next_pc), 32'h0200);
    lat = 1; fl = int'(bus1.flush);
    while (!bus1.br_ready && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      fl += int'(bus1.flush);
    end
    chk({name, " ready latency"}, 32'(lat), 32'd2);
    chk({name, " flush cycles"}, 32'(fl), 32'd1);
    chk({name, " taken_cnt"}, 32'(bus1.taken_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int cyc, fl, res, unstable, stall_bad;

    vecs[0] = '{"beq_eq",   BR_BEQ, 16'h1234, 16'h1234, 16'h0040, 16'h0011, 1'b1, 16'h0040, 1'b0};
    vecs[1] = '{"bne_eq",   BR_BNE, 16'h00FF, 16'h00FF, 16'h0050, 16'h0021, 1'b0, 16'h0021, 1'b0};
    vecs[2] = '{"beq_msb",  BR_BEQ, 16'h0001, 16'h8001, 16'h0060, 16'h0031, 1'b0, 16'h0031, 1'b0};
    vecs[3] = '{"bne_ne",   BR_BNE, 16'h0000, 16'h0001, 16'h0070, 16'h0041, 1'b1, 16'h0070, 1'b0};
    vecs[4] = '{"jmp",      BR_JMP, 16'h0005, 16'h0006, 16'h0080, 16'h0051, 1'b1, 16'h0080, 1'b0};
    vecs[5] = '{"rsv",      BR_RSV, 16'h0007, 16'h0007, 16'h0090, 16'h0061, 1'b0, 16'h0061, 1'b1};
    vecs[6] = '{"beq_ones", BR_BEQ, 16'hFFFF, 16'hFFFF, 16'hFFF0, 16'h0071, 1'b1, 16'hFFF0, 1'b0};

    idle_inputs();
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("rst sel", 32'(bus0.sel), 32'd0);
    chk("rst next_pc", 32'(bus0.next_pc), 32'd0);
    chk("rst resolved", 32'(bus0.resolved), 32'd0);
    chk("rst flush", 32'(bus0.flush), 32'd0);
    chk("rst bad_op", 32'(bus0.bad_op), 32'd0);
    chk("rst taken_cnt", 32'(bus0.taken_cnt), 32'd0);
    chk("rst br_ready", 32'(bus0.br_ready), 32'd1);
    chk("rst1 taken_cnt", 32'(bus1.taken_cnt), 32'd0);

    for (int i = 0; i < 7; i++) do_branch0(vecs[i]);

    // JMP stalled for three cycles starting in RESOLVE.
    bus0.br_op = BR_JMP; bus0.target = 16'h0100; bus0.pc_plus = 16'h0102;
    bus0.br_valid = 1'b1;
    @(posedge clk);
    cyc = 0; fl = 0; res = 0; unstable = 0; stall_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus0.br_valid = 1'b0;
      bus0.stall = (cyc <= 3);
      #1;
      fl  += int'(bus0.flush);
      res += int'(bus0.resolved);
      if (bus0.sel !== 1'b1 || bus0.next_pc !== 16'h0100) unstable++;
      if (cyc <= 3 && (bus0.resolved !== 1'b0 || bus0.flush !== 1'b1)) stall_bad++;
    end while (!bus0.br_ready && cyc < 20);
    chk("stall ready cycle", 32'(cyc), 32'd6);
    chk("stall flush cycles", 32'(fl), 32'd5);
    chk("stall resolved pulses", 32'(res), 32'd1);
    chk("stall outputs while stalled", 32'(stall_bad), 32'd0);
    chk("stall sel/next_pc unstable", 32'(unstable), 32'd0);
    exp_cnt0++;
    chk("stall taken_cnt", 32'(bus0.taken_cnt), 32'(exp_cnt0));

    // Reset during the second flush cycle.
    bus0.br_op = BR_BEQ; bus0.rs_a = 16'h5555; bus0.rs_b = 16'h5555;
    bus0.target = 16'h0300; bus0.pc_plus = 16'h0301; bus0.br_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.br_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midflush flush before rst", 32'(bus0.flush), 32'd1);
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    chk("midflush rst flush", 32'(bus0.flush), 32'd0);
    chk("midflush rst sel", 32'(bus0.sel), 32'd0);
    chk("midflush rst next_pc", 32'(bus0.next_pc), 32'd0);
    chk("midflush rst taken_cnt", 32'(bus0.taken_cnt), 32'd0);
    chk("midflush rst br_ready", 32'(bus0.br_ready), 32'd1);

    // Single-cycle flush variant and counter saturation.
    jmp1("fc1 jmp", 16'd1);
    force dut1.taken_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut1.taken_cnt_q;
    #1;
    jmp1("fc1 jmp to max", 16'hFFFF);
    jmp1("fc1 jmp saturated", 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch resolution unit of the RISC CPU; it drives the select line consumed by the BrEq 2:1 next-PC mux (Sel=1 → branch target, Sel=0 → sequential PC).
- Accepts a branch request from decode, compares two register operands, registers the taken/not-taken decision and next PC, and flushes younger pipeline stages for a fixed number of cycles after a taken branch.
- Also keeps a saturating count of taken branches for performance debug.

Parameters:
- WIDTH, 16, data and PC width in bits.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  branch request present.
- br_ready  out  1  unit can accept a request this cycle.
- br_op  in  2  00 BEQ, 01 BNE, 10 JMP (unconditional), 11 reserved.
- rs_a  in  WIDTH  first compare operand.
- rs_b  in  WIDTH  second compare operand.
- target  in  WIDTH  branch target address.
- pc_plus  in  WIDTH  sequential next PC.
- stall  in  1  global pipeline stall.
- sel  out  1  to the BrEq Sel input; 1 = take target.
- next_pc  out  WIDTH  resolved next PC; equals target when sel=1, pc_plus when sel=0.
- resolved  out  1  one-cycle pulse when the decision is valid.
- flush  out  1  squash younger stages.
- bad_op  out  1  one-cycle pulse with `resolved` when br_op=11.
- taken_cnt  out  16  saturating count of taken branches.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, sel=0, next_pc=0, resolved=0, flush=0, bad_op=0, taken_cnt=0, flush counter=0. Reset wins over every other input in any state, including mid-flush.
- br_ready=1 only in IDLE with stall=0. A request is accepted when br_valid & br_ready are both high at an edge.
- Taken decision:
  - BEQ: rs_a==rs_b.
  - BNE: rs_a!=rs_b.
  - JMP: always taken.
  - op 11: not taken.
  - Compare is full WIDTH, unsigned bit equality.
- Capture on acceptance: sel ← taken; next_pc ← taken ? target : pc_plus; bad_op_q ← (br_op==11). These values are registered and then held stable until the next acceptance or reset.
- State IDLE: on acceptance → RESOLVE; otherwise stay.
- State RESOLVE:
  - If stall=1: hold state; resolved=0; flush follows sel.
  - If stall=0: resolved=1 and bad_op=bad_op_q for this cycle. Then:
    - not taken → IDLE;
    - taken and FLUSH_CYCLES==1 → IDLE;
    - taken otherwise → FLUSH with counter=FLUSH_CYCLES-1.
- State FLUSH: flush=1. If stall=0, the counter decrements; when the counter reaches 1 and stall=0, go to IDLE. If stall=1, the counter freezes.
- Flush output: flush = sel & (state==RESOLVE | state==FLUSH). Total flush duration with no stall is exactly FLUSH_CYCLES cycles, starting the cycle after acceptance.
- Latency: acceptance at edge N → resolved high during cycle N+1, unless stalled.
  - Not-taken: br_ready is high again in cycle N+2.
  - Taken: br_ready is high again in cycle N+1+FLUSH_CYCLES.
- taken_cnt: increments by 1 in the RESOLVE & !stall cycle when sel=1. It saturates at 0xFFFF and never wraps.
- br_valid outside IDLE is ignored; upstream must hold the request until it sees br_ready.

Decomposition:
- Shared package cpu_pkg holds:
  - br_op encodings BR_BEQ=2'b00, BR_BNE=2'b01, BR_JMP=2'b10, BR_RSV=2'b11;
  - the state encoding IDLE/RESOLVE/FLUSH;
  - the TAKEN_CNT_W=16 constant.
- One natural sub-module: br_cmp, the combinational taken-decision from br_op, rs_a and rs_b. It is reusable by a future early-resolve stage.
- FSM, flush counter and perf counter stay in branch_ctrl.

Test Plan:
- Reset then BEQ with rs_a=0x1234, rs_b=0x1234, target=0x0040, pc_plus=0x0011 → next cycle sel=1, next_pc=0x0040, resolved=1; flush high for exactly 2 cycles; br_ready returns 3 cycles after acceptance; taken_cnt=1.
- BNE with rs_a=rs_b=0x00FF, pc_plus=0x0021 → sel=0, next_pc=0x0021, resolved=1, flush never high; br_ready high again 2 cycles after acceptance.
- JMP with target=0x0100, and stall=1 for 3 cycles starting in the RESOLVE cycle → resolved stays 0 and flush stays 1 while stalled; resolved pulses once when stall drops; total flush cycles=2+3; sel and next_pc stable throughout.
- br_op=11 → resolved=1 and bad_op=1 for the same single cycle, sel=0, taken_cnt unchanged.
- rst asserted in the second FLUSH cycle → next cycle flush=0, sel=0, next_pc=0, taken_cnt=0, br_ready=1.
- Preload via 65535 taken JMPs (or force), then one more JMP → taken_cnt stays 0xFFFF; WIDTH=16 and FLUSH_CYCLES=1 variant shows a 1-cycle flush only.
